// File: rtl/multdiv_booth_ctrl.sv
// multdiv_booth_ctrl: sequential signed radix-2 Booth multiplier that borrows the shared ALU adder
module multdiv_booth_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_ovf,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   state_e             state_q;
   logic [WIDTH-1:0]   m_q;
   logic [2*WIDTH:0]   p_q;
   logic [2*WIDTH:0]   p_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               run;
   logic               s;
   logic               exc_d;
   logic [WIDTH-1:0]   result_q;
   logic               exc_q;
   logic               rdy_q;
   logic               busy_q;

   assign hi  = p_q[2*WIDTH:WIDTH+1];
   assign lo  = p_q[WIDTH:1];
   assign run = state_q == RUN;

   // Booth recode of {q0, q_1} onto the shared adder; idle adder inputs stay quiet outside RUN
   always_comb begin
      add_a   = run ? hi : '0;
      add_b   = !run ? '0 : (p_q[1:0] == 2'b01) ? m_q : (p_q[1:0] == 2'b10) ? ~m_q : '0;
      add_cin = run && p_q[1:0] == 2'b10;
      s       = add_sum[WIDTH-1] ^ add_ovf;
      p_d     = {s, add_sum, lo};
      exc_d   = ~(&p_q[2*WIDTH:WIDTH] | ~|p_q[2*WIDTH:WIDTH]);
   end

   // Control FSM, datapath registers and registered handshake outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         m_q      <= '0;
         p_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         case (state_q)
            IDLE: begin
               busy_q <= ctrl_MULT;
               if (ctrl_MULT) begin
                  m_q     <= data_operandA;
                  p_q     <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               p_q     <= p_d;
               cnt_q   <= cnt_q + 1'b1;
               state_q <= (cnt_q == CNT_W'(WIDTH - 1)) ? DONE : RUN;
            end
            DONE: begin
               result_q <= lo;
               exc_q    <= exc_d;
               rdy_q    <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_multdiv_booth_ctrl.sv
// tb_multdiv_booth_ctrl: scoreboard bench with a behavioural adder and a 64-bit multiply reference
module tb_multdiv_booth_ctrl;
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        ctrl_MULT = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] add_a, add_b, add_sum, data_result;
   logic        add_cin, add_ovf, data_exception, data_resultRDY, busy;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int rdy_cnt  = 0;
   logic [32:0] exp_q[$];

   multdiv_booth_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clock(clock), .resetn(resetn), .ctrl_MULT(ctrl_MULT),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_ovf(add_ovf),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy)
   );

   // shared ALU adder as the execute stage would provide it
   assign add_sum = add_a + add_b + {31'b0, add_cin};
   assign add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
      longint prod;
      logic [31:0] lo;
      prod = longint'($signed(a)) * longint'($signed(b));
      lo = prod[31:0];
      return {lo, prod != longint'($signed(lo))};
   endfunction

   // monitor: every RDY pulse is matched against the oldest expected response
   always @(negedge clock) begin
      logic [32:0] e;
      if (data_resultRDY) begin
         rdy_cnt++;
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_rdy: got result %h with no pending request", data_result);
         end else begin
            e = exp_q.pop_front();
            check("result", data_result, e[32:1]);
            check("exception", {31'b0, data_exception}, {31'b0, e[0]});
         end
      end
   end

   task automatic start(input logic [31:0] a, input logic [31:0] b, input bit push);
      @(negedge clock);
      check("adder_idle", add_a | add_b | {31'b0, add_cin}, 32'h0);
      ctrl_MULT = 1'b1;
      data_operandA = a;
      data_operandB = b;
      if (push) exp_q.push_back(model(a, b));
      @(negedge clock);
      ctrl_MULT = 1'b0;
      check("busy_start", {31'b0, busy}, 32'h1);
   endtask

   task automatic wait_rdy(input bit disturb);
      int k = 1;
      while (!data_resultRDY && k < 100) begin
         if (disturb && k == 5) begin
            ctrl_MULT = 1'b1;
            data_operandA = $urandom;
            data_operandB = $urandom;
         end
         if (disturb && k == 6) ctrl_MULT = 1'b0;
         @(negedge clock);
         k++;
      end
      if (k >= 100) begin
         chk_cnt++;
         $display("FAIL rdy_timeout: no RDY within %0d cycles, required 34", k);
      end else begin
         check("latency", k, 34);
         check("busy_rdy", {31'b0, busy}, 32'h1);
      end
      @(negedge clock);
      check("rdy_pulse", {31'b0, data_resultRDY}, 32'h0);
      check("busy_after", {31'b0, busy}, 32'h0);
   endtask

   task automatic mult(input logic [31:0] a, input logic [31:0] b);
      start(a, b, 1'b1);
      wait_rdy(1'b0);
   endtask

   initial begin
      int r0;
      #1;
      check("rst_result", data_result, 32'h0);
      check("rst_flags", {28'b0, data_exception, data_resultRDY, busy, add_cin}, 32'h0);
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      mult(32'd7, 32'd6);
      mult(32'hFFFFFFFD, 32'd5);
      mult(32'h0, 32'h7FFFFFFF);
      mult(32'h80000000, 32'hFFFFFFFF);
      mult(32'h00010000, 32'h00010000);
      mult(32'h0000FFFF, 32'h00008000);
      mult(32'h7FFFFFFF, 32'h7FFFFFFF);
      mult(32'h80000000, 32'h80000000);
      // second start and operand changes mid-run must not matter
      r0 = rdy_cnt;
      start(32'd1234, 32'hFFFFFF00, 1'b1);
      wait_rdy(1'b1);
      repeat (40) @(negedge clock);
      check("single_rdy", rdy_cnt - r0, 1);
      for (int i = 0; i < 12; i++)
         mult($urandom, (i % 3 == 0) ? $urandom_range(0, 255) : $urandom);
      // abort mid-operation: outputs clear at once and no RDY follows
      r0 = rdy_cnt;
      start(32'h12345678, 32'h9ABCDEF0, 1'b0);
      repeat (9) @(negedge clock);
      check("busy_mid", {31'b0, busy}, 32'h1);
      #2 resetn = 1'b0;
      #1;
      check("abort_result", data_result, 32'h0);
      check("abort_flags", {29'b0, data_exception, data_resultRDY, busy}, 32'h0);
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      repeat (40) @(negedge clock);
      check("abort_no_rdy", rdy_cnt - r0, 0);
      mult(32'hFFFFFFF9, 32'hFFFFFFFA);
      mult(32'd100000, 32'd100000);
      repeat (3) @(negedge clock);
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
